// File: rtl/adc_sequencer.sv
// Two-channel ADC sequencer: loads amplifier gains, fires periodic conversions and
// reports block averages of 2^AVG_LOG2 samples per channel, with deferred gain updates.
module adc_sequencer #(
  parameter int unsigned PERIOD   = 300,
  parameter int unsigned AVG_LOG2 = 2,
  parameter logic [3:0]  GAIN_A   = 4'b0001,
  parameter logic [3:0]  GAIN_B   = 4'b1000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  output logic        amp_trig,
  output logic [3:0]  amp_a,
  output logic [3:0]  amp_b,
  input  logic        amp_done,
  output logic        adc_trig,
  input  logic        adc_done,
  input  logic [13:0] adc_a,
  input  logic [13:0] adc_b,
  input  logic        mode,
  input  logic        start,
  input  logic        gain_wr,
  input  logic [3:0]  gain_a_in,
  input  logic [3:0]  gain_b_in,
  output logic [13:0] avg_a,
  output logic [13:0] avg_b,
  output logic        avg_valid,
  output logic        busy,
  output logic        timeout_err,
  input  logic [3:0]  sw,
  output logic [7:0]  led
);
  localparam int AW = 14 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {AMP_LOAD, AMP_WAIT, IDLE, WAIT, CONV} state_t;

  state_t               r_state, w_next;
  logic [3:0]           r_gain_a, r_gain_b, r_pend_a, r_pend_b;
  logic                 r_pend;
  logic [27:0]          r_per_cnt;
  logic [TW-1:0]        r_to_cnt;
  logic signed [AW-1:0] r_acc_a, r_acc_b, w_sum_a, w_sum_b;
  logic [CW-1:0]        r_smp_cnt;
  logic [13:0]          r_avg_a, r_avg_b;
  logic                 r_avg_valid, r_adc_trig, r_tout_err;
  logic [7:0]           r_led;
  logic                 w_move, w_acc, w_fin, w_clr, w_trig, w_tout;

  assign w_sum_a = r_acc_a + AW'($signed(adc_a));
  assign w_sum_b = r_acc_b + AW'($signed(adc_b));

  always_ff @(posedge CLK50MHZ) begin
    if (RST) r_state <= AMP_LOAD;
    else     r_state <= w_next;
  end

  // Pending gains always win over sampling; a gain change restarts the average.
  always_comb begin
    w_next = r_state;
    w_move = 1'b0;
    w_acc  = 1'b0;
    w_fin  = 1'b0;
    w_clr  = 1'b0;
    w_trig = 1'b0;
    w_tout = 1'b0;
    case (r_state)
      AMP_LOAD: w_next = AMP_WAIT;
      AMP_WAIT: if (amp_done) begin
        if (r_pend) begin w_move = 1'b1; w_next = AMP_LOAD; end
        else w_next = mode ? WAIT : IDLE;
      end
      IDLE: if (r_pend) begin w_move = 1'b1; w_clr = 1'b1; w_next = AMP_LOAD; end
        else if (start) w_next = WAIT;
      WAIT: if (r_pend) begin w_move = 1'b1; w_clr = 1'b1; w_next = AMP_LOAD; end
        else if (r_per_cnt == 28'(PERIOD - 1)) begin w_trig = 1'b1; w_next = CONV; end
      CONV: if (adc_done) begin
        if (r_pend) begin w_move = 1'b1; w_clr = 1'b1; w_next = AMP_LOAD; end
        else if (r_smp_cnt == CW'((1 << AVG_LOG2) - 1)) begin
          w_fin = 1'b1; w_clr = 1'b1; w_next = mode ? WAIT : IDLE;
        end else begin w_acc = 1'b1; w_next = WAIT; end
      end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
        w_tout = 1'b1; w_next = WAIT;
      end
      default: w_next = AMP_LOAD;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      r_gain_a    <= GAIN_A;
      r_gain_b    <= GAIN_B;
      r_pend_a    <= '0;
      r_pend_b    <= '0;
      r_pend      <= 1'b0;
      r_per_cnt   <= '0;
      r_to_cnt    <= '0;
      r_acc_a     <= '0;
      r_acc_b     <= '0;
      r_smp_cnt   <= '0;
      r_avg_a     <= '0;
      r_avg_b     <= '0;
      r_avg_valid <= 1'b0;
      r_adc_trig  <= 1'b0;
      r_tout_err  <= 1'b0;
      r_led       <= 8'haa;
    end else begin
      r_per_cnt   <= (r_state == WAIT) ? r_per_cnt + 28'd1 : '0;
      r_to_cnt    <= (r_state == CONV) ? r_to_cnt + TW'(1) : '0;
      r_adc_trig  <= w_trig;
      r_avg_valid <= w_fin;
      if (w_tout) r_tout_err <= 1'b1;
      if (w_move) begin
        r_gain_a <= r_pend_a;
        r_gain_b <= r_pend_b;
        r_pend   <= 1'b0;
      end
      // A write landing on the same cycle as a move stays pending for the next load.
      if (gain_wr) begin
        r_pend_a <= gain_a_in;
        r_pend_b <= gain_b_in;
        r_pend   <= 1'b1;
      end
      if (w_clr) begin
        r_acc_a   <= '0;
        r_acc_b   <= '0;
        r_smp_cnt <= '0;
      end else if (w_acc) begin
        r_acc_a   <= w_sum_a;
        r_acc_b   <= w_sum_b;
        r_smp_cnt <= r_smp_cnt + CW'(1);
      end
      if (w_fin) begin
        r_avg_a <= 14'(w_sum_a >>> AVG_LOG2);
        r_avg_b <= 14'(w_sum_b >>> AVG_LOG2);
      end
      if (r_avg_valid) begin
        case (sw)
          4'd1:    r_led <= r_avg_a[7:0];
          4'd2:    r_led <= {2'b0, r_avg_a[13:8]};
          4'd4:    r_led <= r_avg_b[7:0];
          4'd8:    r_led <= {2'b0, r_avg_b[13:8]};
          default: r_led <= {6'b0, r_tout_err, mode};
        endcase
      end
    end
  end

  assign amp_trig    = (r_state == AMP_LOAD) && !RST;
  assign amp_a       = r_gain_a;
  assign amp_b       = r_gain_b;
  assign adc_trig    = r_adc_trig;
  assign avg_a       = r_avg_a;
  assign avg_b       = r_avg_b;
  assign avg_valid   = r_avg_valid;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_tout_err;
  assign led         = r_led;
endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: an amplifier/ADC responder model plus a table of
// averaging vectors and hand-written sequences for single-shot, gain, timeout and reset.
module tb_adc_sequencer;
  localparam int PER = 4;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        amp_trig, adc_trig, avg_valid, busy, timeout_err;
  logic [3:0]  amp_a, amp_b;
  logic        amp_done = 1'b0, adc_done = 1'b0;
  logic [13:0] adc_a = '0, adc_b = '0;
  logic        mode, start, gain_wr;
  logic [3:0]  gain_a_in, gain_b_in, sw;
  logic [13:0] avg_a, avg_b;
  logic [7:0]  led;

  adc_sequencer #(.PERIOD(PER), .AVG_LOG2(2), .GAIN_A(4'b0001), .GAIN_B(4'b1000),
                  .TIMEOUT(TO)) dut (
    .CLK50MHZ(clk), .RST(rst), .amp_trig(amp_trig), .amp_a(amp_a), .amp_b(amp_b),
    .amp_done(amp_done), .adc_trig(adc_trig), .adc_done(adc_done), .adc_a(adc_a),
    .adc_b(adc_b), .mode(mode), .start(start), .gain_wr(gain_wr), .gain_a_in(gain_a_in),
    .gain_b_in(gain_b_in), .avg_a(avg_a), .avg_b(avg_b), .avg_valid(avg_valid),
    .busy(busy), .timeout_err(timeout_err), .sw(sw), .led(led));

  always #10 clk = ~clk;

  logic [13:0] samp_a [256];
  logic [13:0] samp_b [256];
  logic        adc_en;
  int idx = 0, cyc = 0, amp_cd = 0, adc_cd = 0, trig_cyc = 0, done_cyc = 0;
  int last_sp = 0, lat = 0, n_trig = 0, n_avg = 0;
  int n_chk = 0, n_pass = 0;

  // Responder: amp_done 3 cycles after amp_trig, adc_done 2 cycles after adc_trig.
  initial forever begin
    @(negedge clk); #2;
    cyc++;
    amp_done = 1'b0;
    adc_done = 1'b0;
    if (amp_cd > 0) begin amp_cd--; if (amp_cd == 0) amp_done = 1'b1; end
    if (adc_cd > 0) begin
      adc_cd--;
      if (adc_cd == 0 && adc_en) begin
        adc_done = 1'b1;
        adc_a    = samp_a[idx % 256];
        adc_b    = samp_b[idx % 256];
        idx++;
        done_cyc = cyc;
      end
    end
    if (amp_trig) amp_cd = 3;
    if (adc_trig) begin adc_cd = 2; n_trig++; last_sp = cyc - trig_cyc; trig_cyc = cyc; end
    if (avg_valid) begin n_avg++; lat = cyc - done_cyc; end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_ev(input int sel, input int lim, input string nm);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if ((sel == 0 && adc_trig) || (sel == 1 && avg_valid) || (sel == 2 && amp_trig)) return;
      n++;
      if (n >= lim) begin
        n_chk++;
        $display("FAIL %s: event not seen within %0d cycles", nm, lim);
        return;
      end
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, " amp_trig"}, amp_trig, 0);
    chk({p, " adc_trig"}, adc_trig, 0);
    chk({p, " avg_valid"}, avg_valid, 0);
    chk({p, " avg_a"}, avg_a, 0);
    chk({p, " avg_b"}, avg_b, 0);
    chk({p, " timeout_err"}, timeout_err, 0);
    chk({p, " led"}, led, 8'haa);
    chk({p, " amp_a"}, amp_a, 4'b0001);
    chk({p, " amp_b"}, amp_b, 4'b1000);
  endtask

  task automatic put(input int k, input logic [13:0] a, input logic [13:0] b);
    samp_a[(idx + k) % 256] = a;
    samp_b[(idx + k) % 256] = b;
  endtask

  typedef struct {
    logic [3:0][13:0] sa;
    logic [3:0][13:0] sb;
    logic [3:0]       sw;
    logic [13:0]      ea;
    logic [13:0]      eb;
    logic [7:0]       eled;
  } vec_t;

  initial begin
    vec_t vt[6];
    int base_trig, base_avg, n;
    vt[0] = '{sa:{14'd100, 14'd100, 14'd100, 14'd100}, sb:{14'd100, 14'd100, 14'd100, 14'd100},
              sw:4'd1, ea:14'd100, eb:14'd100, eled:8'h64};
    vt[1] = '{sa:{14'd100, 14'd100, 14'd100, 14'd100}, sb:{14'h3FFC, 14'h3FFD, 14'h3FFE, 14'h3FFF},
              sw:4'd4, ea:14'd100, eb:14'h3FFD, eled:8'hFD};
    vt[2] = '{sa:{14'h2ABC, 14'h2ABC, 14'h2ABC, 14'h2ABC}, sb:{14'd0, 14'd0, 14'd0, 14'd0},
              sw:4'd2, ea:14'h2ABC, eb:14'd0, eled:8'h2A};
    vt[3] = '{sa:{14'd5, 14'd3, 14'd2, 14'd1}, sb:{14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h1FFF},
              sw:4'd8, ea:14'd2, eb:14'h1FFF, eled:8'h1F};
    vt[4] = '{sa:{14'h2000, 14'h2000, 14'h2000, 14'h2000}, sb:{14'h3FF9, 14'd7, 14'h3FFB, 14'd5},
              sw:4'd0, ea:14'h2000, eb:14'd0, eled:8'h01};
    vt[5] = '{sa:{14'd0, 14'd0, 14'd0, 14'd3}, sb:{14'd0, 14'd0, 14'd0, 14'h3FFF},
              sw:4'd4, ea:14'd0, eb:14'h3FFF, eled:8'hFF};

    for (int j = 0; j < 256; j++) begin samp_a[j] = '0; samp_b[j] = '0; end
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 4; k++) begin
        samp_a[i * 4 + k] = vt[i].sa[k];
        samp_b[i * 4 + k] = vt[i].sb[k];
      end
    rst = 1'b1; mode = 1'b1; start = 1'b0; gain_wr = 1'b0;
    gain_a_in = '0; gain_b_in = '0; sw = vt[0].sw; adc_en = 1'b1;

    repeat (3) @(negedge clk);
    chk_reset("reset");
    chk("reset busy", busy, 1);
    rst = 1'b0;
    #1 chk("amp_trig after reset", amp_trig, 1);

    // Continuous-mode averaging vectors.
    for (int i = 0; i < 6; i++) begin
      sw = vt[i].sw;
      wait_ev(1, 200, $sformatf("vec%0d avg_valid", i));
      chk($sformatf("vec%0d avg_a", i), avg_a, vt[i].ea);
      chk($sformatf("vec%0d avg_b", i), avg_b, vt[i].eb);
      @(negedge clk);
      chk($sformatf("vec%0d led", i), led, vt[i].eled);
      chk($sformatf("vec%0d avg_valid latency", i), lat, 1);
    end
    chk("adc_trig spacing", last_sp, PER + 3);

    // Single-shot: the mode change applies at the next average completion.
    mode = 1'b0;
    wait_ev(1, 100, "mode0 drain avg");
    @(negedge clk);
    chk("mode0 busy idle", busy, 0);
    base_trig = n_trig;
    repeat (30) @(negedge clk);
    chk("mode0 no trig before start", n_trig - base_trig, 0);
    put(0, 14'd10, 14'(-10)); put(1, 14'd20, 14'(-20));
    put(2, 14'd30, 14'(-30)); put(3, 14'd40, 14'(-40));
    base_avg = n_avg;
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_ev(1, 100, "single-shot avg");
    chk("single-shot avg_a", avg_a, 14'd25);
    chk("single-shot avg_b", avg_b, 14'h3FE7);
    repeat (20) @(negedge clk);
    chk("single-shot trig count", n_trig - base_trig, 4);
    chk("single-shot avg count", n_avg - base_avg, 1);
    chk("single-shot busy low", busy, 0);

    // Gain write during CONV discards that sample and the partial sum.
    mode = 1'b1;
    put(0, 14'd1000, 14'd1000); put(1, 14'd1000, 14'd1000);
    for (int k = 2; k < 6; k++) put(k, 14'd40, 14'd40);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_ev(0, 20, "gain trig1");
    wait_ev(0, 20, "gain trig2");
    base_avg = n_avg;
    gain_a_in = 4'd5; gain_b_in = 4'd6; gain_wr = 1'b1;
    @(negedge clk); gain_wr = 1'b0;
    wait_ev(2, 20, "gain amp_trig");
    chk("gain amp_a", amp_a, 4'd5);
    chk("gain amp_b", amp_b, 4'd6);
    chk("gain no avg_valid", n_avg - base_avg, 0);
    wait_ev(1, 200, "gain restart avg");
    chk("gain restart avg_a", avg_a, 14'd40);
    chk("gain restart avg_b", avg_b, 14'd40);

    // Withheld adc_done: timeout after exactly TO cycles in CONV, then resume.
    adc_en = 1'b0;
    wait_ev(0, 20, "timeout trig");
    n = 0;
    while (!timeout_err && n < TO + 10) begin @(negedge clk); n++; end
    chk("timeout cycles", n, TO);
    adc_en = 1'b1;
    sw = 4'd0;
    wait_ev(1, 200, "resume avg");
    @(negedge clk);
    chk("led status after timeout", led, 8'h03);

    // Reset mid-CONV with a partial sum; a late adc_done must be ignored.
    for (int k = 0; k < 4; k++) put(k, 14'd500, 14'd500);
    wait_ev(0, 20, "rst trig1");
    wait_ev(0, 20, "rst trig2");
    rst = 1'b1;
    @(negedge clk);
    chk_reset("mid-conv reset");
    rst = 1'b0;
    #1 chk("amp_trig after mid-conv reset", amp_trig, 1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) put(k, 14'(-20), 14'd33);
    wait_ev(1, 200, "post-reset avg");
    chk("post-reset avg_a", avg_a, 14'h3FEC);
    chk("post-reset avg_b", avg_b, 14'd33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adc_sequencer.md
ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PERIOD, 300, clocks from entering WAIT to adc_trig; legal range 2..2^27.
- AVG_LOG2, 2, log2 of samples averaged per result; legal range 0..6.
- GAIN_A, 4'b0001, amplifier A gain code loaded at reset.
- GAIN_B, 4'b1000, amplifier B gain code loaded at reset.
- TIMEOUT, 1024, max clocks in CONV waiting for adc_done.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- CLK50MHZ in 1 clock; RST in 1 reset, synchronous, active-high.
- amp_trig out 1 one-cycle amplifier load pulse; amp_a out 4 / amp_b out 4 gain codes; amp_done in 1 amplifier load finished.
- adc_trig out 1 one-cycle conversion pulse; adc_done in 1 conversion finished; adc_a in 14 / adc_b in 14 two's-complement samples.
- mode in 1 (1 = continuous, 0 = single-shot); start in 1 single-shot request.
- gain_wr in 1 gain update strobe; gain_a_in in 4 / gain_b_in in 4 new codes.
- avg_a out 14 / avg_b out 14 averaged results; avg_valid out 1 one-cycle result strobe.
- busy out 1; timeout_err out 1 sticky.
- sw in 4 LED select; led out 8 display.

Function
REQ-003 FSM states SHALL be AMP_LOAD, AMP_WAIT, IDLE, WAIT, CONV.
- AMP_LOAD -> AMP_WAIT after one cycle.
- AMP_WAIT -> WAIT on amp_done if mode=1; -> IDLE if mode=0.
- IDLE -> WAIT on start.
- WAIT -> CONV when the period count reaches PERIOD-1.
- CONV -> WAIT, IDLE or AMP_LOAD on adc_done or timeout, per REQ-007 and REQ-009.
REQ-004 amp_trig SHALL be high exactly while in AMP_LOAD; amp_a/amp_b SHALL show the active gain registers at all times.
REQ-005 Period counter SHALL clear on entry to WAIT, count only in WAIT, and cause adc_trig high for exactly the one cycle of the WAIT->CONV transition.
REQ-006 On adc_done in CONV, adc_a/adc_b SHALL be sign-extended to 14+AVG_LOG2 bits and added to the accumulators; the sample counter SHALL increment.
REQ-007 When the sample counter reaches 2^AVG_LOG2:
- avg_a/avg_b SHALL take accumulator arithmetic-shifted right by AVG_LOG2, truncated to 14 bits;
- avg_valid SHALL pulse one cycle, one cycle after the final adc_done;
- accumulators and counter SHALL clear;
- FSM SHALL go to WAIT if mode=1, IDLE if mode=0.
REQ-008 Otherwise adc_done SHALL return the FSM to WAIT, so one single-shot start yields one full average.
REQ-009 gain_wr in any state SHALL latch gain_a_in/gain_b_in into pending registers and set a pending flag; a later gain_wr overwrites the pending values.
- In IDLE or WAIT, pending SHALL move to active and the FSM go to AMP_LOAD next cycle; a partial accumulation is discarded.
- In CONV, the move is deferred until adc_done; that sample is discarded and avg_valid is not pulsed.
- In AMP_LOAD/AMP_WAIT, the move is deferred until amp_done, then a further AMP_LOAD occurs.
REQ-010 If TIMEOUT cycles elapse in CONV without adc_done:
- timeout_err SHALL set (sticky until RST);
- the sample SHALL be dropped;
- the FSM SHALL go to WAIT.
REQ-011 adc_done outside CONV and amp_done outside AMP_WAIT SHALL be ignored.
REQ-012 start SHALL be ignored outside IDLE.
REQ-013 A mode change SHALL take effect only at the next decision point (AMP_WAIT exit or average completion).
REQ-014 busy SHALL be high in every state except IDLE.
REQ-015 led SHALL update on avg_valid from sw:
- 1 -> avg_a[7:0]; 2 -> {2'b0,avg_a[13:8]}; 4 -> avg_b[7:0]; 8 -> {2'b0,avg_b[13:8]};
- other -> {6'b0, timeout_err, mode}.

Reset
REQ-016 While RST is high at a clock edge:
- state SHALL be AMP_LOAD, gains GAIN_A/GAIN_B, pending cleared;
- accumulators, counters, avg_a, avg_b SHALL be 0;
- avg_valid, adc_trig, amp_trig, timeout_err SHALL be 0; led SHALL be 8'haa.
REQ-017 amp_trig SHALL assert in the first cycle after RST falls.
REQ-018 RST mid-conversion SHALL abandon the accumulation; a late adc_done SHALL be ignored.

Verification
REQ-019 Bench SHALL cover:
- Reset, PERIOD=4, AVG_LOG2=2, mode=1, amp_done 3 cycles after amp_trig, adc_done 2 cycles after adc_trig, all samples 100 -> avg_a=100 after 4th adc_done; adc_trig spacing 4+2+1 clocks.
- Samples -1,-2,-3,-4 on adc_b -> avg_b=14'h3FFD (-3, floor).
- mode=0: no adc_trig until start; one start -> exactly 4 adc_trig, 1 avg_valid, busy then low.
- gain_wr (5,6) during CONV -> after adc_done amp_trig with amp_a=5, amp_b=6; no avg_valid; accumulation restarts.
- adc_done withheld -> timeout_err=1 after TIMEOUT cycles; sequencing resumes.
- sw=2 with avg_a=14'h2ABC -> led=8'h2A; RST mid-CONV -> outputs at REQ-016 values.
